// File: rtl/clk_ratio_bank.sv
// clk_ratio_bank: programmable multi-channel clock ratio generator.
// A master counter defines a frame of P int_osc cycles. Each channel produces a square
// wave whose period is the frame multiplied or divided by its own factor. New channel
// settings wait in a single pending slot and take effect at a frame boundary.
module clk_ratio_bank #(
    parameter int DATA_WIDTH = 20,
    parameter int NUM_CH     = 4,
    parameter int FACT_W     = 5,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  int_osc,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] master_period,
    input  logic [DATA_WIDTH-1:0] duty_cycle,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic                  cfg_mode,
    input  logic [FACT_W-1:0]     cfg_factor,
    input  logic                  cfg_enable,
    output logic                  frame_start,
    output logic [NUM_CH-1:0]     ch_out,
    output logic [NUM_CH-1:0]     ch_err
);

    localparam int PW = DATA_WIDTH + FACT_W;
    localparam int MW = PW + DATA_WIDTH;

    typedef enum logic {
        MODE_DIV = 1'b0,
        MODE_MUL = 1'b1
    } mode_t;

    // Master frame state. r_live is low only in the first cycle after reset, so the
    // first frame starts one cycle after rst falls.
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_mcnt;
    logic [DATA_WIDTH-1:0] r_P;

    // Single pending configuration slot.
    logic                  r_pendValid;
    logic [CH_W-1:0]       r_pendCh;
    mode_t                 r_pendMode;
    logic [FACT_W-1:0]     r_pendFactor;
    logic                  r_pendEnable;

    // Committed per-channel settings and running state.
    logic [NUM_CH-1:0]     r_en;
    mode_t                 r_mode  [NUM_CH];
    logic [FACT_W-1:0]     r_F     [NUM_CH];
    logic [PW-1:0]         r_Pc    [NUM_CH];
    logic [PW-1:0]         r_Hc    [NUM_CH];
    logic [PW-1:0]         r_cnt   [NUM_CH];
    logic [FACT_W-1:0]     r_sub   [NUM_CH];

    logic                  w_fs;
    logic [DATA_WIDTH-1:0] w_pNew;
    logic [DATA_WIDTH-1:0] w_pEff;
    logic                  w_pChg;

    logic [NUM_CH-1:0]     w_en;
    logic [NUM_CH-1:0]     w_commit;
    logic [NUM_CH-1:0]     w_restart;
    logic [NUM_CH-1:0]     w_ok;
    mode_t                 w_mode    [NUM_CH];
    logic [FACT_W-1:0]     w_F       [NUM_CH];
    logic [PW-1:0]         w_pcNew   [NUM_CH];
    logic [MW-1:0]         w_prod    [NUM_CH];
    logic [PW-1:0]         w_hRaw    [NUM_CH];
    logic [PW-1:0]         w_hcNew   [NUM_CH];
    logic [PW-1:0]         w_pcEff   [NUM_CH];
    logic [PW-1:0]         w_hcEff   [NUM_CH];
    logic [PW-1:0]         w_cntEff  [NUM_CH];
    logic [PW-1:0]         w_cntNext [NUM_CH];
    logic [FACT_W-1:0]     w_subEff  [NUM_CH];
    logic [FACT_W-1:0]     w_subNext [NUM_CH];

    // Frame boundary detection; the new period is used immediately in the boundary cycle.
    always_comb begin
        w_fs   = r_live && (r_mcnt == '0);
        w_pNew = (master_period < DATA_WIDTH'(2)) ? DATA_WIDTH'(2) : master_period;
        w_pEff = w_fs ? w_pNew : r_P;
        w_pChg = (w_pNew != r_P);
    end

    // Per-channel datapath: at a frame boundary the new settings are already visible so a
    // restarting channel rises in the same cycle as frame_start.
    always_comb begin
        w_en      = '0;
        w_commit  = '0;
        w_restart = '0;
        w_ok      = '0;
        ch_out    = '0;
        ch_err    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_commit[c] = w_fs && r_pendValid && (r_pendCh == CH_W'(c));
            w_en[c]     = w_commit[c] ? r_pendEnable : r_en[c];
            w_mode[c]   = w_commit[c] ? r_pendMode   : r_mode[c];
            w_F[c]      = w_commit[c] ? r_pendFactor : r_F[c];
            w_restart[c] = w_fs && ((w_mode[c] == MODE_MUL) || w_commit[c] || w_pChg);

            if (w_mode[c] == MODE_MUL) begin
                w_pcNew[c] = PW'(w_pNew) / PW'(w_F[c]);
            end else begin
                w_pcNew[c] = PW'(w_pNew) * PW'(w_F[c]);
            end
            w_prod[c] = MW'(w_pcNew[c]) * MW'(duty_cycle);
            w_hRaw[c] = PW'(w_prod[c] >> DATA_WIDTH);
            if (w_hRaw[c] == '0) begin
                w_hcNew[c] = PW'(1);
            end else if (w_hRaw[c] >= w_pcNew[c]) begin
                w_hcNew[c] = w_pcNew[c] - PW'(1);
            end else begin
                w_hcNew[c] = w_hRaw[c];
            end

            w_pcEff[c]  = w_fs ? w_pcNew[c] : r_Pc[c];
            w_hcEff[c]  = w_fs ? w_hcNew[c] : r_Hc[c];
            w_ok[c]     = (w_pcEff[c] >= PW'(2));
            w_cntEff[c] = w_restart[c] ? '0 : r_cnt[c];
            w_subEff[c] = w_restart[c] ? '0 : r_sub[c];

            w_cntNext[c] = '0;
            w_subNext[c] = '0;
            if (w_en[c] && w_ok[c]) begin
                if (w_mode[c] == MODE_DIV) begin
                    w_cntNext[c] = (w_cntEff[c] == w_pcEff[c] - PW'(1)) ? '0 : w_cntEff[c] + PW'(1);
                end else if (w_cntEff[c] != w_pcEff[c] - PW'(1)) begin
                    w_cntNext[c] = w_cntEff[c] + PW'(1);
                    w_subNext[c] = w_subEff[c];
                end else if (w_subEff[c] == w_F[c] - FACT_W'(1)) begin
                    w_cntNext[c] = w_cntEff[c];
                    w_subNext[c] = w_subEff[c];
                end else begin
                    w_cntNext[c] = '0;
                    w_subNext[c] = w_subEff[c] + FACT_W'(1);
                end
            end

            ch_out[c] = w_en[c] && w_ok[c] && (w_cntEff[c] < w_hcEff[c]);
            ch_err[c] = w_en[c] && !w_ok[c];
        end
    end

    assign frame_start = w_fs;
    assign cfg_ready   = !r_pendValid;

    // Master counter runs 0..P-1 and latches the period at each frame boundary.
    always_ff @(posedge int_osc) begin
        if (rst) begin
            r_live <= 1'b0;
            r_mcnt <= '0;
            r_P    <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_fs) begin
                r_P <= w_pNew;
            end
            if (!r_live || (r_mcnt == w_pEff - DATA_WIDTH'(1))) begin
                r_mcnt <= '0;
            end else begin
                r_mcnt <= r_mcnt + DATA_WIDTH'(1);
            end
        end
    end

    // Pending slot: capture on handshake, release at the next frame boundary.
    always_ff @(posedge int_osc) begin
        if (rst) begin
            r_pendValid  <= 1'b0;
            r_pendCh     <= '0;
            r_pendMode   <= MODE_DIV;
            r_pendFactor <= FACT_W'(1);
            r_pendEnable <= 1'b0;
        end else if (!r_pendValid) begin
            if (cfg_valid) begin
                r_pendValid  <= 1'b1;
                r_pendCh     <= cfg_ch;
                r_pendMode   <= mode_t'(cfg_mode);
                r_pendFactor <= (cfg_factor == '0) ? FACT_W'(1) : cfg_factor;
                r_pendEnable <= cfg_enable;
            end
        end else if (w_fs) begin
            r_pendValid <= 1'b0;
        end
    end

    // Channel registers: settings and derived timing update per frame, counters every cycle.
    always_ff @(posedge int_osc) begin
        if (rst) begin
            r_en <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_mode[c] <= MODE_DIV;
                r_F[c]    <= FACT_W'(1);
                r_Pc[c]   <= '0;
                r_Hc[c]   <= '0;
                r_cnt[c]  <= '0;
                r_sub[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_fs) begin
                    r_en[c]   <= w_en[c];
                    r_mode[c] <= w_mode[c];
                    r_F[c]    <= w_F[c];
                    r_Pc[c]   <= w_pcNew[c];
                    r_Hc[c]   <= w_hcNew[c];
                end
                r_cnt[c] <= w_cntNext[c];
                r_sub[c] <= w_subNext[c];
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_bank.sv
// Testbench for clk_ratio_bank: directed scenarios followed by random traffic, every
// cycle compared against a frame-level arithmetic model of the channel waveforms.
module tb_clk_ratio_bank;

    localparam int DW  = 20;
    localparam int NCH = 4;
    localparam int FW  = 5;
    localparam int CW  = 2;

    logic           int_osc;
    logic           rst;
    logic [DW-1:0]  master_period;
    logic [DW-1:0]  duty_cycle;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic           cfg_mode;
    logic [FW-1:0]  cfg_factor;
    logic           cfg_enable;
    logic           frame_start;
    logic [NCH-1:0] ch_out;
    logic [NCH-1:0] ch_err;

    clk_ratio_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FACT_W(FW)) dut (
        .int_osc(int_osc), .rst(rst),
        .master_period(master_period), .duty_cycle(duty_cycle),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_factor(cfg_factor), .cfg_enable(cfg_enable),
        .frame_start(frame_start), .ch_out(ch_out), .ch_err(ch_err)
    );

    initial int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    int passCount  = 0;
    int checkTotal = 0;
    int failCount  = 0;

    // Reference model state: frame position, pending slot, per-channel settings.
    bit     mLive;
    int     mOff;
    int     mP;
    longint mDuty;
    bit     pendV;
    int     pendCh;
    bit     pendMul;
    int     pendF;
    bit     pendEn;
    bit     commitNow;
    longint cyc = 0;
    bit     chEn[NCH];
    bit     chMul[NCH];
    int     chF[NCH];
    longint chPc[NCH];
    longint chHc[NCH];
    longint chAnchor[NCH];

    function automatic longint periodOf(int p, bit mul, int f);
        return mul ? longint'(p / f) : longint'(p) * longint'(f);
    endfunction

    function automatic longint highOf(longint pc, longint d);
        longint h;
        h = (pc * d) >> DW;
        if (h < 1) h = 1;
        if (h > pc - 1) h = pc - 1;
        return h;
    endfunction

    task automatic modelReset;
        mLive = 0; mOff = 0; mP = 0; mDuty = 0;
        pendV = 0; commitNow = 0;
        for (int c = 0; c < NCH; c++) begin
            chEn[c] = 0; chMul[c] = 0; chF[c] = 1;
            chPc[c] = 0; chHc[c] = 0; chAnchor[c] = 0;
        end
    endtask

    // Applies frame-boundary effects for the current cycle (period, duty, commit, restarts).
    task automatic modelFrame;
        int newP;
        bit pChg;
        commitNow = 0;
        if (mLive && mOff == 0) begin
            newP  = (master_period < 2) ? 2 : int'(master_period);
            pChg  = (newP != mP);
            mP    = newP;
            mDuty = longint'(duty_cycle);
            if (pendV) begin
                commitNow      = 1;
                chEn[pendCh]   = pendEn;
                chMul[pendCh]  = pendMul;
                chF[pendCh]    = pendF;
            end
            for (int c = 0; c < NCH; c++) begin
                chPc[c] = periodOf(mP, chMul[c], chF[c]);
                chHc[c] = highOf(chPc[c], mDuty);
                if (chMul[c] || pChg || (commitNow && c == pendCh)) chAnchor[c] = cyc;
            end
        end
    endtask

    // Clock edge: reset, handshake capture or release, frame position advance.
    task automatic modelEdge;
        if (rst) begin
            modelReset();
        end else begin
            if (!pendV) begin
                if (cfg_valid) begin
                    pendV   = 1;
                    pendCh  = int'(cfg_ch);
                    pendMul = cfg_mode;
                    pendF   = (cfg_factor == 0) ? 1 : int'(cfg_factor);
                    pendEn  = cfg_enable;
                end
            end else if (commitNow) begin
                pendV = 0;
            end
            if (!mLive) begin
                mLive = 1;
                mOff  = 0;
            end else begin
                mOff = mOff + 1;
                if (mOff >= mP) mOff = 0;
            end
        end
        commitNow = 0;
        cyc = cyc + 1;
    endtask

    task automatic checkOutput;
        bit             expFs;
        bit             expReady;
        logic [NCH-1:0] expOut;
        logic [NCH-1:0] expErr;
        longint         k;
        longint         pos;
        expFs    = mLive && (mOff == 0);
        expReady = !pendV;
        expOut   = '0;
        expErr   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chEn[c]) begin
                if (chPc[c] < 2) begin
                    expErr[c] = 1'b1;
                end else if (chMul[c]) begin
                    k = longint'(mOff) / chPc[c];
                    if (k > chF[c] - 1) k = chF[c] - 1;
                    pos = longint'(mOff) - k * chPc[c];
                    expOut[c] = (pos < chHc[c]);
                end else begin
                    pos = (cyc - chAnchor[c]) % chPc[c];
                    expOut[c] = (pos < chHc[c]);
                end
            end
        end
        checkTotal++;
        assert (frame_start === expFs) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL frame_start cyc=%0d observed=%0b expected=%0b", cyc, frame_start, expFs);
        end
        checkTotal++;
        assert (cfg_ready === expReady) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL cfg_ready cyc=%0d observed=%0b expected=%0b", cyc, cfg_ready, expReady);
        end
        checkTotal++;
        assert (ch_out === expOut) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL ch_out cyc=%0d observed=%b expected=%b", cyc, ch_out, expOut);
        end
        checkTotal++;
        assert (ch_err === expErr) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL ch_err cyc=%0d observed=%b expected=%b", cyc, ch_err, expErr);
        end
    endtask

    task automatic tick;
        @(negedge int_osc);
        modelFrame();
        checkOutput();
        @(posedge int_osc);
        modelEdge();
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input bit v, input int ch, input bit mode, input int f, input bit en);
        cfg_valid  = v;
        cfg_ch     = CW'(ch);
        cfg_mode   = mode;
        cfg_factor = FW'(f);
        cfg_enable = en;
    endtask

    task automatic waitOffset(input int n);
        for (int i = 0; i < 64 && !(mLive && mOff == n); i++) tick();
    endtask

    task automatic sendCfg(input int ch, input bit mode, input int f, input bit en);
        for (int i = 0; i < 200 && pendV; i++) tick();
        applyStimulus(1'b1, ch, mode, f, en);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        master_period = DW'(10);
        duty_cycle    = 20'h80000;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        @(posedge int_osc);
        modelReset();
        #1;
        runCycles(3);

        $display("[TB] reset released, P=10, D=half");
        rst = 1'b0;
        runCycles(25);

        $display("[TB] ch0 divide by 4");
        sendCfg(0, 1'b0, 4, 1'b1);
        runCycles(90);

        $display("[TB] ch1 multiply by 3");
        sendCfg(1, 1'b1, 3, 1'b1);
        runCycles(45);

        $display("[TB] period 10 -> 20 mid-frame");
        waitOffset(4);
        master_period = DW'(20);
        runCycles(100);

        $display("[TB] config while slot busy is ignored");
        waitOffset(2);
        sendCfg(3, 1'b0, 2, 1'b1);
        applyStimulus(1'b1, 2, 1'b0, 7, 1'b1);
        runCycles(3);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        runCycles(60);

        $display("[TB] ch2 multiply by 8 at P=10 is unrealisable");
        master_period = DW'(10);
        sendCfg(2, 1'b1, 8, 1'b1);
        runCycles(50);

        $display("[TB] factor 0, duty extremes, tiny periods");
        sendCfg(3, 1'b1, 0, 1'b1);
        duty_cycle = '0;
        runCycles(50);
        duty_cycle = '1;
        runCycles(50);
        master_period = DW'(1);
        runCycles(30);
        master_period = DW'(0);
        runCycles(10);

        $display("[TB] reset mid-frame with a pending config");
        master_period = DW'(10);
        duty_cycle    = 20'h80000;
        runCycles(20);
        waitOffset(5);
        sendCfg(0, 1'b0, 2, 1'b0);
        rst = 1'b1;
        runCycles(2);
        rst = 1'b0;
        runCycles(40);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) master_period = DW'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0:       duty_cycle = '0;
                    1:       duty_cycle = '1;
                    default: duty_cycle = DW'($urandom);
                endcase
            end
            applyStimulus($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                          $urandom_range(0, 4) != 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        runCycles(20);

        $display("%0d/%0d checks passed", passCount, checkTotal);
        $finish;
    end

endmodule
